// File: rtl/aes_inv_round_engine_if.sv
// Block-level bus of the AES inverse round engine: ciphertext in, plaintext out,
// and the lookup port into the external expanded-key store.
interface aes_inv_round_engine_if;
  // A transfer happens on a rising edge where valid and ready are both high. The
  // payload is held stable while valid is high and ready is low. valid never
  // waits on ready, and a dropped ready never loses a pending result.
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;

  modport master (
    output in_valid, ciphertext, round_key, out_ready,
    input  in_ready, key_idx, out_valid, plaintext
  );

  modport slave (
    input  in_valid, ciphertext, round_key, out_ready,
    output in_ready, key_idx, out_valid, plaintext
  );
endinterface

// File: rtl/aes_inv_round_engine.sv
// Iterative AES inverse cipher that runs one round per clock over a single 128-bit state register.
// Defining AES_INV_ROUND_OUTBUF_EN adds a one-deep output buffer, so the next block can start while a result waits.
module aes_inv_round_engine #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  aes_inv_round_engine_if.slave bus,
  output logic [1:0]            o_dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2, DONE = 2'd3} fsm_t;

  localparam logic [3:0] KEY_LAST  = 4'(NR);
  localparam logic [3:0] RND_FIRST = 4'(NR - 1);

  fsm_t         r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_rnd;
  logic [3:0]   r_key_idx;
  logic         r_in_ready;
`ifdef AES_INV_ROUND_OUTBUF_EN
  logic [127:0] r_obuf;
  logic         r_obuf_valid;
`else
  logic         r_out_valid;
`endif
  logic [127:0] w_isr_isb;
  logic [127:0] w_final_out;
  logic [127:0] w_round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse computed as a^254; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, sq);
      sq = gf_mul(sq, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // A full round adds the key before InvMixColumns, so it reuses the final-round output.
  assign w_isr_isb   = inv_sub_bytes(inv_shift_rows(r_state));
  assign w_final_out = w_isr_isb ^ bus.round_key;
  assign w_round_out = inv_mix_columns(w_final_out);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm      <= IDLE;
      r_state    <= '0;
      r_rnd      <= '0;
      r_key_idx  <= KEY_LAST;
      r_in_ready <= 1'b1;
`ifdef AES_INV_ROUND_OUTBUF_EN
      r_obuf       <= '0;
      r_obuf_valid <= 1'b0;
`else
      r_out_valid <= 1'b0;
`endif
    end else begin
`ifdef AES_INV_ROUND_OUTBUF_EN
      if (bus.out_ready) r_obuf_valid <= 1'b0;
`endif
      case (r_fsm)
        IDLE: begin
          if (bus.in_valid) begin
            r_state    <= bus.ciphertext ^ bus.round_key;
            r_rnd      <= RND_FIRST;
            r_key_idx  <= RND_FIRST;
            r_in_ready <= 1'b0;
            r_fsm      <= ROUND;
          end
        end
        ROUND: begin
          r_state <= w_round_out;
          r_rnd   <= r_rnd - 4'd1;
          if (r_rnd == 4'd1) begin
            r_key_idx <= 4'd0;
            r_fsm     <= FINAL;
          end else begin
            r_key_idx <= r_rnd - 4'd1;
          end
        end
        FINAL: begin
`ifdef AES_INV_ROUND_OUTBUF_EN
          // The result skips DONE whenever the buffer is free or drains on this same edge.
          if (!r_obuf_valid || bus.out_ready) begin
            r_obuf       <= w_final_out;
            r_obuf_valid <= 1'b1;
            r_in_ready   <= 1'b1;
            r_key_idx    <= KEY_LAST;
            r_fsm        <= IDLE;
          end else begin
            r_state <= w_final_out;
            r_fsm   <= DONE;
          end
`else
          r_state     <= w_final_out;
          r_out_valid <= 1'b1;
          r_fsm       <= DONE;
`endif
        end
        DONE: begin
`ifdef AES_INV_ROUND_OUTBUF_EN
          if (!r_obuf_valid || bus.out_ready) begin
            r_obuf       <= r_state;
            r_obuf_valid <= 1'b1;
            r_in_ready   <= 1'b1;
            r_key_idx    <= KEY_LAST;
            r_fsm        <= IDLE;
          end
`else
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_key_idx   <= KEY_LAST;
            r_fsm       <= IDLE;
          end
`endif
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.key_idx  = r_key_idx;
`ifdef AES_INV_ROUND_OUTBUF_EN
  assign bus.out_valid = r_obuf_valid;
  assign bus.plaintext = r_obuf;
`else
  assign bus.out_valid = r_out_valid;
  assign bus.plaintext = r_state;
`endif
  assign o_dbg_state = r_fsm;
endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Bench for aes_inv_round_engine: one engine each for AES-128, AES-192 and AES-256, checked against a byte-level AES model.
module tb_aes_inv_round_engine;
  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT10    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT12    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT14    = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_FIPS = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- DUT hookup ----------------
  logic         in_valid_a [3];
  logic [127:0] ct_a       [3];
  logic         out_ready_a[3];
  logic         in_ready_a [3];
  logic         out_valid_a[3];
  logic [3:0]   key_idx_a  [3];
  logic [127:0] pt_a       [3];
  logic [1:0]   dbg_a      [3];
  logic [127:0] rk_tab     [3][16];

  aes_inv_round_engine_if b0();
  aes_inv_round_engine_if b1();
  aes_inv_round_engine_if b2();

  aes_inv_round_engine #(.NR(10)) u_dut10 (.clk(clk), .reset(reset), .bus(b0), .o_dbg_state(dbg_a[0]));
  aes_inv_round_engine #(.NR(12)) u_dut12 (.clk(clk), .reset(reset), .bus(b1), .o_dbg_state(dbg_a[1]));
  aes_inv_round_engine #(.NR(14)) u_dut14 (.clk(clk), .reset(reset), .bus(b2), .o_dbg_state(dbg_a[2]));

  assign b0.in_valid   = in_valid_a[0];
  assign b0.ciphertext = ct_a[0];
  assign b0.out_ready  = out_ready_a[0];
  assign b0.round_key  = rk_tab[0][b0.key_idx];
  assign in_ready_a[0] = b0.in_ready;
  assign out_valid_a[0] = b0.out_valid;
  assign key_idx_a[0]  = b0.key_idx;
  assign pt_a[0]       = b0.plaintext;

  assign b1.in_valid   = in_valid_a[1];
  assign b1.ciphertext = ct_a[1];
  assign b1.out_ready  = out_ready_a[1];
  assign b1.round_key  = rk_tab[1][b1.key_idx];
  assign in_ready_a[1] = b1.in_ready;
  assign out_valid_a[1] = b1.out_valid;
  assign key_idx_a[1]  = b1.key_idx;
  assign pt_a[1]       = b1.plaintext;

  assign b2.in_valid   = in_valid_a[2];
  assign b2.ciphertext = ct_a[2];
  assign b2.out_ready  = out_ready_a[2];
  assign b2.round_key  = rk_tab[2][b2.key_idx];
  assign in_ready_a[2] = b2.in_ready;
  assign out_valid_a[2] = b2.out_valid;
  assign key_idx_a[2]  = b2.key_idx;
  assign pt_a[2]       = b2.plaintext;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox[256];
  logic [7:0] inv_sbox[256];

  function automatic logic [7:0] gf_mul_m(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul_m(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_sbox[sbox[x]] = 8'(x);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand_key(input int inst, input int nr, input logic [255:0] key);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk;
    nk   = nr - 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gf_mul_m(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk_tab[inst][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_decrypt(input int inst, input int nr, input logic [127:0] blk);
    logic [7:0]   st[4][4];
    logic [7:0]   tmp[4][4];
    logic [7:0]   coef[4];
    logic [127:0] res;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) st[r][c] = blk[127 - 8*(4*c + r) -: 8];
    for (int rd = nr; rd >= 0; rd--) begin
      if (rd != nr) begin
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) tmp[r][(c + r) % 4] = inv_sbox[st[r][c]];
        st = tmp;
      end
      for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ rk_tab[inst][rd][127 - 8*(4*c + r) -: 8];
      if (rd != nr && rd != 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            tmp[r][c] = 8'h00;
            for (int k = 0; k < 4; k++) tmp[r][c] = tmp[r][c] ^ gf_mul_m(st[k][c], coef[(k - r + 4) % 4]);
          end
        st = tmp;
      end
    end
    res = '0;
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) res[127 - 8*(4*c + r) -: 8] = st[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_block(input int inst, input int nr, input logic [127:0] c, input logic [127:0] exp_pt);
    @(negedge clk);
    check("idle_in_ready", 128'(in_ready_a[inst]), 128'(1));
    check("idle_key_idx", 128'(key_idx_a[inst]), 128'(nr));
    ct_a[inst] = c;
    in_valid_a[inst] = 1'b1;
    out_ready_a[inst] = 1'b1;
    exp_q.push_back(exp_pt);
    @(posedge clk);
    for (int e = 1; e <= nr; e++) begin
      @(negedge clk);
      in_valid_a[inst] = 1'b0;
      ct_a[inst] = rand128();
      check("key_idx_seq", 128'(key_idx_a[inst]), 128'(nr - e));
      check("early_out_valid", 128'(out_valid_a[inst]), 128'(0));
      @(posedge clk);
    end
    @(negedge clk);
    check("latency_out_valid", 128'(out_valid_a[inst]), 128'(1));
    check("plaintext", pt_a[inst], exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    check("post_out_valid", 128'(out_valid_a[inst]), 128'(0));
    check("post_in_ready", 128'(in_ready_a[inst]), 128'(1));
  endtask

  task automatic stall_test();
    logic [127:0] c;
    logic [127:0] exp_pt;
    c = rand128();
    exp_pt = model_decrypt(0, 10, c);
    @(negedge clk);
    ct_a[0] = c;
    in_valid_a[0] = 1'b1;
    out_ready_a[0] = 1'b0;
    @(posedge clk);
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      in_valid_a[0] = 1'b0;
      @(posedge clk);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("stall_out_valid", 128'(out_valid_a[0]), 128'(1));
      check("stall_plaintext", pt_a[0], exp_pt);
`ifndef AES_INV_ROUND_OUTBUF_EN
      check("stall_in_ready", 128'(in_ready_a[0]), 128'(0));
      in_valid_a[0] = 1'($urandom_range(0, 1));
      ct_a[0] = rand128();
`endif
      @(posedge clk);
    end
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    out_ready_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_out_valid", 128'(out_valid_a[0]), 128'(0));
    check("release_in_ready", 128'(in_ready_a[0]), 128'(1));
    @(posedge clk);
    @(negedge clk);
    check("single_transfer", 128'(out_valid_a[0]), 128'(0));
  endtask

  task automatic reset_mid_test();
    int seen_valid;
    @(negedge clk);
    ct_a[0] = rand128();
    in_valid_a[0] = 1'b1;
    out_ready_a[0] = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      in_valid_a[0] = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_in_ready", 128'(in_ready_a[0]), 128'(1));
    check("midrst_out_valid", 128'(out_valid_a[0]), 128'(0));
    check("midrst_key_idx", 128'(key_idx_a[0]), 128'(10));
    check("midrst_plaintext", pt_a[0], 128'(0));
    seen_valid = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (out_valid_a[0]) seen_valid++;
    end
    check("midrst_no_output", 128'(seen_valid), 128'(0));
  endtask

`ifdef AES_INV_ROUND_OUTBUF_EN
  task automatic stream_test();
    logic [127:0] cts[4];
    logic [127:0] exps[4];
    int n_acc;
    int last_acc;
    logic acc;
    for (int i = 0; i < 4; i++) begin
      cts[i] = rand128();
      exps[i] = model_decrypt(0, 10, cts[i]);
    end
    n_acc = 0;
    last_acc = -1;
    out_ready_a[0] = 1'b1;
    for (int cyc = 0; cyc < 200 && (n_acc < 4 || exp_q.size() > 0); cyc++) begin
      @(negedge clk);
      in_valid_a[0] = (n_acc < 4);
      if (n_acc < 4) ct_a[0] = cts[n_acc];
      if (out_valid_a[0]) begin
        if (exp_q.size() > 0) check("stream_plaintext", pt_a[0], exp_q.pop_front());
        else check("stream_extra_output", 128'(1), 128'(0));
      end
      acc = in_valid_a[0] && in_ready_a[0];
      @(posedge clk);
      if (acc) begin
        if (last_acc >= 0) check("stream_gap", 128'(cyc - last_acc), 128'(11));
        last_acc = cyc;
        exp_q.push_back(exps[n_acc]);
        n_acc++;
      end
    end
    check("stream_accepts", 128'(n_acc), 128'(4));
    check("stream_drained", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  task automatic no_overwrite_test();
    logic [127:0] c1, c2, e1, e2;
    int n_acc;
    logic acc;
    c1 = rand128();
    c2 = rand128();
    e1 = model_decrypt(0, 10, c1);
    e2 = model_decrypt(0, 10, c2);
    out_ready_a[0] = 1'b0;
    n_acc = 0;
    for (int cyc = 0; cyc < 40 && n_acc < 2; cyc++) begin
      @(negedge clk);
      in_valid_a[0] = 1'b1;
      ct_a[0] = (n_acc == 0) ? c1 : c2;
      acc = in_ready_a[0];
      @(posedge clk);
      if (acc) n_acc++;
    end
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    check("ovw_accepts", 128'(n_acc), 128'(2));
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check("ovw_hold_valid", 128'(out_valid_a[0]), 128'(1));
      check("ovw_hold_plaintext", pt_a[0], e1);
    end
    check("ovw_in_ready", 128'(in_ready_a[0]), 128'(0));
    out_ready_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ovw_second_valid", 128'(out_valid_a[0]), 128'(1));
    check("ovw_second_plaintext", pt_a[0], e2);
    @(posedge clk);
    @(negedge clk);
    check("ovw_drained", 128'(out_valid_a[0]), 128'(0));
    check("ovw_idle_ready", 128'(in_ready_a[0]), 128'(1));
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] c;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i] = 1'b0;
      out_ready_a[i] = 1'b0;
      ct_a[i] = '0;
      for (int r = 0; r < 16; r++) rk_tab[i][r] = '0;
    end
    build_sbox();
    expand_key(0, 10, KEY_FIPS);
    expand_key(1, 12, KEY_FIPS);
    expand_key(2, 14, KEY_FIPS);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", 128'(in_ready_a[0]), 128'(1));
    check("rst_out_valid", 128'(out_valid_a[0]), 128'(0));
    check("rst_plaintext", pt_a[0], 128'(0));
    check("rst_key_idx10", 128'(key_idx_a[0]), 128'(10));
    check("rst_key_idx12", 128'(key_idx_a[1]), 128'(12));
    check("rst_key_idx14", 128'(key_idx_a[2]), 128'(14));

    check("model_fips10", model_decrypt(0, 10, CT10), PT_FIPS);
    check("model_fips14", model_decrypt(2, 14, CT14), PT_FIPS);
    run_block(0, 10, CT10, PT_FIPS);
    run_block(1, 12, CT12, PT_FIPS);
    run_block(2, 14, CT14, PT_FIPS);

    stall_test();
    reset_mid_test();
    c = rand128();
    run_block(0, 10, c, model_decrypt(0, 10, c));

    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 3; n++) begin
        expand_key(i, 10 + 2*i, {rand128(), rand128()});
        c = rand128();
        run_block(i, 10 + 2*i, c, model_decrypt(i, 10 + 2*i, c));
      end
    end

`ifdef AES_INV_ROUND_OUTBUF_EN
    stream_test();
    no_overwrite_test();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "simulation time limit reached");
  end
endmodule

// File: doc/aes_inv_round_engine.md
# aes_inv_round_engine

Iterative AES inverse-cipher datapath: accepts one 128-bit ciphertext block, runs initial AddRoundKey, NR-1 full inverse rounds and one final round over a single 128-bit state register, and returns the plaintext. Wraps the combinational inverse stages (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) in a state register and FSM. Feeds the inverse mix-columns stage and consumes its output every round. Round keys come from an external expanded-key store indexed by this block.

## Interface
- NR, 10, number of rounds; legal values 10/12/14 (AES-128/192/256); other values unsupported
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext offered
- in_ready  out  1  block can accept ciphertext
- ciphertext  in  128  input block; byte 0 at [127:120]; column c at [127-32c -: 32], row 0 in top byte of each column
- key_idx  out  4  round-key index requested, NR down to 0
- round_key  in  128  round key for key_idx, valid in the same cycle (combinational store read)
- out_valid  out  1  plaintext valid
- out_ready  in  1  consumer takes plaintext
- plaintext  out  128  result, same byte layout as ciphertext

## Operation
- States: IDLE, ROUND, FINAL, DONE. Round counter rnd, 4 bits.
- IDLE: in_ready=1, key_idx=NR. On in_valid&&in_ready: state <= ciphertext ^ round_key; rnd <= NR-1; -> ROUND.
- ROUND: key_idx=rnd. Each cycle state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key); rnd <= rnd-1. When rnd==1 at the edge -> FINAL.
- FINAL: key_idx=0. state <= InvSubBytes(InvShiftRows(state)) ^ round_key; -> DONE.
- DONE: out_valid=1, plaintext=state. On out_ready -> IDLE. in_ready=0.
- in_ready=0 in ROUND/FINAL/DONE; in_valid ignored there, ciphertext not sampled.
- key_idx, in_ready, out_valid decoded from registered state only; no combinational path from any input to any output except none (round_key reaches only the state register D input).
- GF(2^8) arithmetic modulo 0x11B; all XORs bytewise, 128-bit, no carries.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, plaintext=0, key_idx=NR, rnd=0, state register=0.
- Latency: out_valid rises NR edges after the accepting edge (10/12/14). Handshake on accept cycle = edge 0; ROUND edges 1..NR-1; FINAL edge NR.
- Throughput (macro off): one block per NR+1+k cycles, k = DONE stall cycles (k>=1 since DONE lasts at least one cycle).
- out_valid held, plaintext stable, until out_ready sampled high; dropping out_ready never loses data.
- reset mid-operation: next edge forces all reset values; partial block discarded, no out_valid.
- round_key sampled only at edges in IDLE-accept, ROUND, FINAL; don't-care otherwise.

## Configuration
- AES_INV_ROUND_OUTBUF_EN defined: adds one-deep output register (obuf, obuf_valid). FINAL writes obuf directly if obuf is empty or drained that same cycle (out_ready high), then -> IDLE; otherwise -> DONE and wait. out_valid=obuf_valid, plaintext=obuf. Next block accepted while result pending; simultaneous accept and out_ready in one cycle both complete. Back-to-back throughput NR+1 cycles/block with out_ready held high.
- Not defined: behaviour as in Operation; no obuf; DONE mandatory for every block.

## Test plan
- NR=10, key 000102…0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> plaintext 00112233445566778899aabbccddeeff, out_valid exactly 10 edges after accept; key_idx sequence 10,9,…,0.
- NR=12 key 0001…1617 ct dda97ca4864cdfe06eaf70a0ec0d7191; NR=14 key 0001…1e1f ct 8ea2b7ca516745bfeafc49904b496089 -> plaintext 00112233…eeff, latency 12/14.
- out_ready held low 20 cycles after completion -> out_valid and plaintext stable, in_ready=0 (macro off), in_valid pulses ignored; release -> single transfer, IDLE next cycle.
- reset asserted on ROUND edge 5 -> next cycle in_ready=1, out_valid=0, key_idx=NR; new block then decrypts correctly.
- Macro on, 4 blocks streamed with in_valid and out_ready always 1 -> accepts every 11 cycles (NR=10), 4 correct outputs in order; with out_ready low, 2nd block stalls in DONE, no overwrite of obuf.
